stl_multichannel_framer: RTL
============================

Name: stl_multichannel_framer

Overview:
- Parametrised successor to the STL UART client: turns the UART handler's byte stream into fixed-size packets for NUM_CHANNELS packet endpoints, and returns those endpoints' responses as a byte stream.
- Each frame carries a channel header byte, so one UART link can serve several serial-TileLink bridges (for example, multiple SCuM-V lanes or a loopback/debug endpoint).
- Adds what the single-channel client lacks: channel routing, bad-channel drop, inter-byte timeout resync, and round-robin response arbitration.

Parameters:
- PACKET_BYTES, 16, payload bytes per packet (>=1); packet width PW = PACKET_BYTES*8.
- NUM_CHANNELS, 2, number of packet endpoints (1..255).
- TIMEOUT_CYCLES, 100000, idle clk cycles allowed inside a partial inbound frame before it is discarded (>=2).

Ports:
- clk  input  1  single clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  byte from UART handler valid.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- in_data  input  8  inbound byte.
- out_valid  output  1  response byte valid.
- out_ready  input  1  UART handler accepts response byte.
- out_data  output  8  response byte.
- pkt_valid  output  NUM_CHANNELS  per-channel inbound packet valid (one-hot or zero).
- pkt_ready  input  NUM_CHANNELS  per-channel packet accept.
- pkt_data  output  PW  inbound packet, shared by all channels; byte k at [8k+7:8k].
- rsp_valid  input  NUM_CHANNELS  per-channel response packet valid.
- rsp_ready  output  NUM_CHANNELS  per-channel response accept (one-hot or zero).
- rsp_data  input  NUM_CHANNELS*PW  channel c response at [c*PW +: PW], same byte order.
- err_bad_channel  output  1  one-cycle pulse when a header byte >= NUM_CHANNELS is accepted.
- err_timeout  output  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset (reset_n low, async): all outputs 0, both FSMs idle, counters 0, RR pointer = NUM_CHANNELS-1 (so channel 0 wins first). in_ready goes to 1 on the first clk edge after release.
- Frame format, both directions: 1 header byte (channel id, full 8 bits compared) followed by PACKET_BYTES payload bytes, payload byte 0 first (LSB first).

RX FSM (RX_HDR, RX_PAYLOAD, RX_DROP, RX_DELIVER):
- in_ready is registered: 1 in HDR/PAYLOAD/DROP, 0 in DELIVER.
- HDR, byte accepted:
  - value < NUM_CHANNELS: latch channel, go to PAYLOAD.
  - otherwise: pulse err_bad_channel next cycle, go to DROP.
- PAYLOAD: each accepted byte is written to byte slot cnt; cnt increments. When the byte with cnt == PACKET_BYTES-1 is accepted, go to DELIVER. pkt_valid[ch] rises on the next cycle (1-cycle latency), and in_ready is 0 in that same cycle.
- DROP: consume PACKET_BYTES bytes, discard them, return to HDR.
- DELIVER: pkt_valid[ch] and pkt_data are held stable until pkt_ready[ch]. On the handshake cycle, go to HDR; pkt_valid is 0 and in_ready is 1 on the next cycle. pkt_ready on other channels is ignored. DELIVER has no timeout.
- Timeout, in PAYLOAD/DROP only:
  - Idle counter clears on every accepted byte and on entry.
  - When it reaches TIMEOUT_CYCLES-1 with no byte accepted: partial frame discarded, cnt = 0, go to HDR, err_timeout pulses for 1 cycle.
  - If a byte is accepted in that same cycle, the byte wins and there is no timeout.
- pkt_data retains the last assembled packet when not valid.

TX FSM (TX_IDLE, TX_HDR, TX_PAYLOAD):
- TX_IDLE: if any rsp_valid is set, grant g = the first asserted index after the RR pointer (wrapping). Assert rsp_ready[g] combinationally for that one cycle, capture rsp_data[g] into the shift register, set RR pointer = g, go to TX_HDR.
- TX_HDR: out_valid=1, out_data=g, held until out_ready.
- TX_PAYLOAD: emit bytes 0..PACKET_BYTES-1 LSB first, advancing only on out_valid && out_ready. After the last byte is accepted, go to TX_IDLE.
- Throughput: PACKET_BYTES+1 bytes per response, plus one idle cycle between responses.
- RX and TX run independently; simultaneous inbound and outbound traffic is legal.
- Reset asserted mid-frame: the partial inbound frame and the in-flight response are lost. The response already received via rsp_ready is not re-requested.

Test Plan (PACKET_BYTES=16, NUM_CHANNELS=2, TIMEOUT_CYCLES=64):
- Send 0x01, then 0x00..0x0F with pkt_ready[1]=1 -> pkt_valid=2'b10 one cycle after the last byte; pkt_data=128'h0F0E...0100; pkt_valid[0] never set; in_ready=0 for exactly 1 cycle.
- Send 0x05 + 16 bytes, then 0x00 + 16 bytes -> err_bad_channel pulses once; no pkt_valid for the first frame; channel 0 then receives the second packet intact.
- Send 0x00 + 5 bytes, stall 64 cycles, then 0x01 + 16 bytes -> err_timeout pulses once; channel 1 receives the correct packet.
- Hold pkt_ready[0]=0 for 200 cycles after a complete frame -> pkt_valid/pkt_data stable; in_ready=0; no timeout; releasing pkt_ready completes the handshake.
- rsp_valid=2'b11 held, out_ready=1 -> byte sequence 0x00 + ch0 payload, then 0x01 + ch1 payload, then ch0 again (round-robin); each rsp_ready is a single-cycle pulse.
- Random out_ready backpressure (50%) during a response, plus reset_n pulsed low mid-payload -> bytes never skipped or duplicated before reset; all outputs 0 immediately on assertion.

Source files
------------

// File: rtl/stl_multichannel_framer.sv
// stl_multichannel_framer
//   Bridges a UART byte stream and NUM_CHANNELS fixed-size packet endpoints.
//   Frames in both directions are: one header byte (channel id), then
//   PACKET_BYTES payload bytes, payload byte 0 first.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   in_valid/in_ready/in_data    inbound bytes from the UART handler
//   out_valid/out_ready/out_data outbound response bytes to the UART handler
//   pkt_valid/pkt_ready          per-channel inbound packet handshake
//   pkt_data                     inbound packet, shared by all channels
//   rsp_valid/rsp_ready          per-channel response packet handshake
//   rsp_data                     channel c response at [c*PW +: PW]
//   err_bad_channel              pulse: header byte >= NUM_CHANNELS accepted
//   err_timeout                  pulse: partial inbound frame discarded
module stl_multichannel_framer #(
  parameter int unsigned PACKET_BYTES   = 16,
  parameter int unsigned NUM_CHANNELS   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [7:0]                             in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [7:0]                             out_data,
  output logic [NUM_CHANNELS-1:0]                pkt_valid,
  input  logic [NUM_CHANNELS-1:0]                pkt_ready,
  output logic [PACKET_BYTES*8-1:0]              pkt_data,
  input  logic [NUM_CHANNELS-1:0]                rsp_valid,
  output logic [NUM_CHANNELS-1:0]                rsp_ready,
  input  logic [NUM_CHANNELS*PACKET_BYTES*8-1:0] rsp_data,
  output logic                                   err_bad_channel,
  output logic                                   err_timeout
);

  localparam int unsigned PW  = PACKET_BYTES * 8;
  localparam int unsigned CHW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned CW  = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES);

  localparam logic [NUM_CHANNELS-1:0] CH_ONE    = NUM_CHANNELS'(1);
  localparam logic [CW-1:0]           LAST_BYTE = CW'(PACKET_BYTES - 1);
  localparam logic [TW-1:0]           IDLE_MAX  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {RX_HDR, RX_PAYLOAD, RX_DROP, RX_DELIVER} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_PAYLOAD} tx_state_t;

  // ---------------------------------------------------------------- RX path
  rx_state_t       rx_state;
  logic [CHW-1:0]  rx_ch;
  logic [CW-1:0]   rx_cnt;
  logic [TW-1:0]   rx_idle;
  logic            accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state        <= RX_HDR;
      rx_ch           <= '0;
      rx_cnt          <= '0;
      rx_idle         <= '0;
      in_ready        <= 1'b0;
      pkt_valid       <= '0;
      pkt_data        <= '0;
      err_bad_channel <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      err_bad_channel <= 1'b0;
      err_timeout     <= 1'b0;
      unique case (rx_state)
        RX_HDR: begin
          in_ready <= 1'b1;
          if (accept) begin
            rx_cnt  <= '0;
            rx_idle <= '0;
            if (32'(in_data) < NUM_CHANNELS) begin
              rx_ch    <= CHW'(in_data);
              rx_state <= RX_PAYLOAD;
            end else begin
              err_bad_channel <= 1'b1;
              rx_state        <= RX_DROP;
            end
          end
        end
        // PAYLOAD and DROP share counting and timeout; only PAYLOAD stores bytes
        RX_PAYLOAD, RX_DROP: begin
          if (accept) begin
            rx_idle <= '0;
            if (rx_state == RX_PAYLOAD) begin
              for (int unsigned k = 0; k < PACKET_BYTES; k++) begin
                if (32'(rx_cnt) == k) pkt_data[k*8 +: 8] <= in_data;
              end
            end
            if (rx_cnt == LAST_BYTE) begin
              rx_cnt <= '0;
              if (rx_state == RX_PAYLOAD) begin
                rx_state  <= RX_DELIVER;
                in_ready  <= 1'b0;
                pkt_valid <= CH_ONE << rx_ch;
              end else begin
                rx_state <= RX_HDR;
              end
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end else if (rx_idle == IDLE_MAX) begin
            rx_idle     <= '0;
            rx_cnt      <= '0;
            rx_state    <= RX_HDR;
            err_timeout <= 1'b1;
          end else begin
            rx_idle <= rx_idle + 1'b1;
          end
        end
        RX_DELIVER: begin
          if (pkt_ready[rx_ch]) begin
            pkt_valid <= '0;
            in_ready  <= 1'b1;
            rx_state  <= RX_HDR;
          end
        end
        default: rx_state <= RX_HDR;
      endcase
    end
  end

  // ---------------------------------------------------------------- TX path
  tx_state_t       tx_state;
  logic [CHW-1:0]  rr_ptr;
  logic [CW-1:0]   tx_cnt;
  logic [PW-1:0]   tx_shift;
  logic            tx_live;
  logic            grant_found;
  logic [CHW-1:0]  grant;
  logic [PW-1:0]   sel_data;

  // Round-robin: first requester strictly after the last granted channel
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
      if (!grant_found && rsp_valid[CHW'((32'(rr_ptr) + i) % NUM_CHANNELS)]) begin
        grant_found = 1'b1;
        grant       = CHW'((32'(rr_ptr) + i) % NUM_CHANNELS);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (32'(grant) == c) sel_data = rsp_data[c*PW +: PW];
    end
  end

  // tx_live keeps rsp_ready low while reset is held and until the first edge
  always_comb begin
    rsp_ready = '0;
    if (tx_live && tx_state == TX_IDLE && grant_found) rsp_ready = CH_ONE << grant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state  <= TX_IDLE;
      rr_ptr    <= CHW'(NUM_CHANNELS - 1);
      tx_cnt    <= '0;
      tx_shift  <= '0;
      tx_live   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      tx_live <= 1'b1;
      unique case (tx_state)
        TX_IDLE: begin
          if (tx_live && grant_found) begin
            tx_shift  <= sel_data;
            rr_ptr    <= grant;
            tx_cnt    <= '0;
            out_valid <= 1'b1;
            out_data  <= 8'(grant);
            tx_state  <= TX_HDR;
          end
        end
        TX_HDR: begin
          if (out_ready) begin
            out_data <= tx_shift[7:0];
            tx_shift <= tx_shift >> 8;
            tx_state <= TX_PAYLOAD;
          end
        end
        TX_PAYLOAD: begin
          if (out_ready) begin
            if (tx_cnt == LAST_BYTE) begin
              out_valid <= 1'b0;
              out_data  <= '0;
              tx_state  <= TX_IDLE;
            end else begin
              tx_cnt   <= tx_cnt + 1'b1;
              out_data <= tx_shift[7:0];
              tx_shift <= tx_shift >> 8;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
